// File: rtl/loadstore_unit.sv
// rtl/loadstore_unit.sv - load/store unit running one Wishbone classic cycle per request
module loadstore_unit #(
    parameter int NUM_REGS = 64,
    parameter int TIMEOUT  = 255,
    localparam int REG_IDX = $clog2(NUM_REGS) - 1
) (
    input  logic               wb_clk_i,
    input  logic               rst,
    input  logic               req_load,
    input  logic               req_store,
    input  logic [31:0]        req_address,
    input  logic [1:0]         req_size,
    input  logic               req_sign_extend,
    input  logic [REG_IDX:0]   req_dest,
    input  logic [31:0]        req_store_val,
    output logic               busy,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [31:0]        wbm_adr_o,
    output logic [31:0]        wbm_dat_o,
    output logic [3:0]         wbm_sel_o,
    input  logic [31:0]        wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic               wr_en,
    output logic [REG_IDX:0]   wr_idx,
    output logic [31:0]        wr_val,
    output logic [1:0]         wr_mask,
    output logic               fault,
    output logic [31:0]        fault_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request context, valid from the accept edge until the next accept.
    logic [31:0]      addr_q;
    logic [3:0]       sel_q;
    logic [31:0]      dat_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic [REG_IDX:0] dest_q;
    logic             is_load_q;
    logic             fault_q;
    logic [7:0]       cnt_q;
    logic [31:0]      wr_val_q;
    logic [31:0]      fault_addr_q;

    // Decoded request and per-cycle decisions.
    logic        req;
    logic        misaligned;
    logic [3:0]  sel_calc;
    logic [31:0] dat_calc;
    logic        accept_ok;
    logic        accept_bad;
    logic        bus_ack;
    logic        bus_fault;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic        in_bus;
    logic        in_done;

    assign req     = req_load | req_store;
    assign in_bus  = (state_q == S_BUS);
    assign in_done = (state_q == S_DONE);

    // Alignment check, byte-lane selects and lane-replicated store data for the incoming request.
    always_comb begin
        misaligned = 1'b0;
        sel_calc   = 4'b0000;
        dat_calc   = req_store_val;
        case (req_size)
            2'd0: begin
                sel_calc = 4'b0001 << req_address[1:0];
                dat_calc = {4{req_store_val[7:0]}};
            end
            2'd1: begin
                misaligned = req_address[0];
                sel_calc   = req_address[1] ? 4'b1100 : 4'b0011;
                dat_calc   = {2{req_store_val[15:0]}};
            end
            2'd2: begin
                misaligned = (req_address[1:0] != 2'b00);
                sel_calc   = 4'b1111;
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Lane extraction of the returned read data, then zero/sign extension to 32 bits.
    always_comb begin
        shifted  = wbm_dat_i >> {addr_q[1:0], 3'b000};
        load_val = shifted;
        case (size_q)
            2'd0:    load_val = {{24{sign_q & shifted[7]}}, shifted[7:0]};
            2'd1:    load_val = {{16{sign_q & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state logic: accept in IDLE, terminate in BUS, DONE always falls back to IDLE.
    always_comb begin
        state_d    = state_q;
        accept_ok  = 1'b0;
        accept_bad = 1'b0;
        bus_ack    = 1'b0;
        bus_fault  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = misaligned ? S_DONE : S_BUS;
                    accept_ok  = ~misaligned;
                    accept_bad = misaligned;
                end
            end
            S_BUS: begin
                if (wbm_err_i || (!wbm_ack_i && cnt_q == 8'(TIMEOUT))) begin
                    bus_fault = 1'b1;
                    state_d   = S_DONE;
                end else if (wbm_ack_i) begin
                    bus_ack = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; a reset in BUS abandons the access without passing through DONE.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request context, timeout counter, captured load result and fault bookkeeping.
    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            addr_q       <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            sign_q       <= 1'b0;
            dest_q       <= '0;
            is_load_q    <= 1'b0;
            fault_q      <= 1'b0;
            cnt_q        <= '0;
            wr_val_q     <= '0;
            fault_addr_q <= '0;
        end else begin
            if (accept_ok || accept_bad) begin
                addr_q    <= req_address;
                sel_q     <= sel_calc;
                dat_q     <= dat_calc;
                we_q      <= req_store;
                size_q    <= req_size;
                sign_q    <= req_sign_extend;
                dest_q    <= req_dest;
                is_load_q <= req_load;
                fault_q   <= accept_bad;
                cnt_q     <= '0;
            end
            if (accept_bad) begin
                fault_addr_q <= req_address;
            end
            if (in_bus) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (bus_ack && is_load_q) begin
                wr_val_q <= load_val;
            end
            if (bus_fault) begin
                fault_q      <= 1'b1;
                fault_addr_q <= addr_q;
            end
        end
    end

    assign busy       = ~rst & ((state_q == S_IDLE && req) || in_bus);
    assign wbm_cyc_o  = in_bus;
    assign wbm_stb_o  = in_bus;
    assign wbm_we_o   = in_bus & we_q;
    assign wbm_adr_o  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign wbm_sel_o  = in_bus ? sel_q : 4'b0000;
    assign wbm_dat_o  = in_bus ? dat_q : 32'd0;
    assign wr_en      = in_done & is_load_q & ~fault_q;
    assign wr_idx     = dest_q;
    assign wr_val     = wr_val_q;
    assign wr_mask    = wr_en ? 2'b11 : 2'b00;
    assign fault      = in_done & fault_q;
    assign fault_addr = fault_addr_q;

endmodule
